gpio_pin_port: RTL and testbench

//  Pin-side end of the 16-bit I/O port. Drives the bidirectional pads from the OUT and DIR

---
 rtl/gpio_pin_port.sv | 71 +++++++
 tb/tb_gpio_pin_port.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_pin_port.sv
// 16-bit port pin interface: pad drive, sync + per-bit debounce, sticky change flags, maskable irq.
// Latency pin->in_data SYNC_STAGES+DEBOUNCE_CYCLES edges, irq one edge later; no backpressure.
module gpio_pin_port #(
   parameter int WIDTH           = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             RST,
   input  logic [WIDTH-1:0] out_data,
   input  logic [WIDTH-1:0] dir,
   inout  wire  [WIDTH-1:0] pins,
   output logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] chg_flags,
   input  logic [WIDTH-1:0] flag_clr,
   input  logic [WIDTH-1:0] irq_en,
   output logic             irq
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
   logic [CW-1:0]                     r_cnt     [WIDTH];
   logic [CW-1:0]                     w_cnt_nxt [WIDTH];
   logic [WIDTH-1:0]                  w_s;
   logic [WIDTH-1:0]                  w_chg;

   // Output pins are read back through the same sampling path as inputs.
   for (genvar g = 0; g < WIDTH; g++) begin : g_pad
      assign pins[g] = dir[g] ? out_data[g] : 1'bz;
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   always_comb begin
      w_chg = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_cnt_nxt[i] = '0;
         if (w_s[i] != in_data[i]) begin
            if (r_cnt[i] == CNT_LAST) begin
               w_chg[i] = 1'b1;
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         r_sync    <= '0;
         in_data   <= '0;
         chg_flags <= '0;
         irq       <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], pins};
         in_data   <= in_data ^ w_chg;
         // A change event on the same edge as a clear keeps the flag set.
         chg_flags <= (chg_flags & ~flag_clr) | w_chg;
         irq       <= |(chg_flags & irq_en);
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_gpio_pin_port.sv
// Directed bench for gpio_pin_port: reset, pad drive, glitch rejection, irq, set/clear collision.
module tb_gpio_pin_port;

   logic        clk = 1'b0;
   logic        RST;
   logic [15:0] out_data;
   logic [15:0] dir;
   logic [15:0] flag_clr;
   logic [15:0] irq_en;
   logic [15:0] tb_val;
   wire  [15:0] pins;
   logic [15:0] in_data;
   logic [15:0] chg_flags;
   logic        irq;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // The bench acts as the external driver on every pin configured as input.
   for (genvar g = 0; g < 16; g++) begin : g_ext
      assign pins[g] = dir[g] ? 1'bz : tb_val[g];
   end

   gpio_pin_port dut (
      .clk       (clk),
      .RST       (RST),
      .out_data  (out_data),
      .dir       (dir),
      .pins      (pins),
      .in_data   (in_data),
      .chg_flags (chg_flags),
      .flag_clr  (flag_clr),
      .irq_en    (irq_en),
      .irq       (irq)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      RST      = 1'b1;
      dir      = 16'h0000;
      out_data = 16'h0000;
      tb_val   = 16'hFFFF;
      flag_clr = 16'h0000;
      irq_en   = 16'h0000;

      // Reset with all pins high
      #1 RST = 1'b0;
      #1;
      check("rst_in_data", in_data, 16'h0000);
      check("rst_chg", chg_flags, 16'h0000);
      check("rst_irq", {15'd0, irq}, 16'h0000);
      step(3);
      check("rst_held_in_data", in_data, 16'h0000);
      RST = 1'b1;
      step(5);
      check("rel_e5_in_data", in_data, 16'h0000);
      step(1);
      check("rel_e6_in_data", in_data, 16'hFFFF);
      check("rel_e6_chg", chg_flags, 16'hFFFF);
      check("rel_e6_irq_masked", {15'd0, irq}, 16'h0000);
      flag_clr = 16'hFFFF;
      step(1);
      flag_clr = 16'h0000;
      check("clr_all", chg_flags, 16'h0000);

      // Pad drive: low byte output, high byte pulled by bench
      dir      = 16'h00FF;
      out_data = 16'hA5A5;
      tb_val   = 16'h3C00;
      #1;
      check("pins_low_byte", {8'h00, pins[7:0]}, 16'h00A5);
      check("pins_all", pins, 16'h3CA5);
      step(5);
      check("drv_e5_in_data", in_data, 16'hFFFF);
      step(1);
      check("drv_e6_in_data", in_data, 16'h3CA5);
      check("drv_e6_chg", chg_flags, 16'hC35A);
      flag_clr = 16'hFFFF;
      step(1);
      flag_clr = 16'h0000;
      check("drv_clr", chg_flags, 16'h0000);

      // All inputs at the same levels: no events
      dir    = 16'h0000;
      tb_val = 16'h3CA5;
      irq_en = 16'h0008;
      step(8);
      check("dir_flip_in_data", in_data, 16'h3CA5);
      check("dir_flip_chg", chg_flags, 16'h0000);

      // Glitch on bit 3: 3 clk high, then low, must be rejected
      tb_val = 16'h3CAD;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("glitch_hi_in_data", in_data, 16'h3CA5);
      end
      tb_val = 16'h3CA5;
      for (int i = 0; i < 4; i++) begin
         step(1);
         check("glitch_lo_in_data", in_data, 16'h3CA5);
      end
      check("glitch_chg", chg_flags, 16'h0000);
      check("glitch_irq", {15'd0, irq}, 16'h0000);

      // Stable high on bit 3
      tb_val = 16'h3CAD;
      step(5);
      check("b3_e5_in_data", in_data, 16'h3CA5);
      step(1);
      check("b3_e6_in_data", in_data, 16'h3CAD);
      check("b3_e6_chg", chg_flags, 16'h0008);
      check("b3_e6_irq", {15'd0, irq}, 16'h0000);
      step(1);
      check("b3_e7_irq", {15'd0, irq}, 16'h0001);

      // Clear bit 3 flag: flag drops next edge, irq the edge after
      flag_clr = 16'h0008;
      step(1);
      flag_clr = 16'h0000;
      check("clr3_chg", chg_flags, 16'h0000);
      check("clr3_irq_still", {15'd0, irq}, 16'h0001);
      step(1);
      check("clr3_irq_drop", {15'd0, irq}, 16'h0000);

      // Bit 5 falls; clear strobe lands on the same edge as the event
      tb_val = 16'h3C8D;
      step(5);
      flag_clr = 16'h0020;
      step(1);
      flag_clr = 16'h0000;
      check("coll_in_data", in_data, 16'h3C8D);
      check("coll_chg", chg_flags, 16'h0020);
      step(1);
      check("coll_chg_hold", chg_flags, 16'h0020);
      check("coll_irq_masked", {15'd0, irq}, 16'h0000);
      flag_clr = 16'h0020;
      step(1);
      flag_clr = 16'h0000;
      check("coll_clr", chg_flags, 16'h0000);

      // Bit 0 low and settled, then rising edge interrupted by reset
      tb_val = 16'h3C8C;
      step(8);
      check("b0_low_in_data", in_data, 16'h3C8C);
      flag_clr = 16'h0001;
      step(1);
      flag_clr = 16'h0000;
      check("b0_low_clr", chg_flags, 16'h0000);
      tb_val = 16'h3C8D;
      step(4);
      RST = 1'b0;
      #2;
      check("mid_rst_in_data", in_data, 16'h0000);
      check("mid_rst_chg", chg_flags, 16'h0000);
      check("mid_rst_irq", {15'd0, irq}, 16'h0000);
      RST = 1'b1;
      step(5);
      check("mid_rel_e5_in_data", in_data, 16'h0000);
      step(1);
      check("mid_rel_e6_in_data", in_data, 16'h3C8D);
      check("mid_rel_e6_chg", chg_flags, 16'h3C8D);
      step(1);
      check("mid_rel_e7_irq", {15'd0, irq}, 16'h0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
